// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
package uart_pkg;

    // Receiver FSM states; S_WAIT_IDLE parks the FSM after a framing error until the line returns high.
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_IDLE
    } uart_rx_state_t;

    // Clock cycles per bit; integer divide, remainder is absorbed by mid-bit sampling.
    function automatic int calc_div(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with combinational head output. Push while full is
// accepted only when a pop happens in the same cycle; pop while empty is ignored.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             full,
    input  logic             pop,
    output logic             empty,
    output logic [WIDTH-1:0] head
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("sync_fifo: DEPTH must be a power of 2 and at least 2");
        end
    endgenerate

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_pop;
    logic             do_push;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign head    = mem[rd_ptr];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Storage, pointers and occupancy; simultaneous push/pop leaves count unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx.sv
// Oversampling 8N1 UART receiver: synchroniser, false-start rejection,
// 3-sample majority vote, framing-error detection and an output FIFO.
// Handshake: a byte is transferred on every rising CLK edge where VALID && READY;
// DATA is stable while VALID is high and READY is low.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 48000000,
    parameter int BAUD     = 3000000,
    parameter int DEPTH    = 4
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       RX,
    output logic [7:0] DATA,
    output logic       VALID,
    input  logic       READY,
    output logic       FRAME_ERR,
    output logic       OVERRUN
);
    localparam int DIV = calc_div(CLK_FREQ, BAUD);
    localparam int MID = DIV / 2;
    localparam int CW  = $clog2(DIV);
    localparam logic [CW-1:0] CNT_S0   = CW'(MID - 1);
    localparam logic [CW-1:0] CNT_S1   = CW'(MID);
    localparam logic [CW-1:0] CNT_VOTE = CW'(MID + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

    generate
        if (DIV < 8) begin : g_bad_div
            $error("uart_rx: CLK_FREQ/BAUD must be at least 8");
        end
    endgenerate

    logic           sync1;
    logic           rxs;
    logic           rxs_d;
    logic           samp0;
    logic           samp1;
    logic           vote;
    logic           at_vote;
    logic           at_last;
    uart_rx_state_t state;      // observable FSM state for debug
    logic [CW-1:0]  cnt;
    logic [2:0]     bit_idx;
    logic [7:0]     shreg;
    logic           fifo_full;
    logic           fifo_empty;
    logic           pop;
    logic           push;

    assign at_vote = (cnt == CNT_VOTE);
    assign at_last = (cnt == CNT_LAST);
    assign vote    = (samp0 & samp1) | (samp0 & rxs) | (samp1 & rxs);
    assign VALID   = !fifo_empty;
    assign pop     = VALID && READY;
    assign push    = (state == S_STOP) && at_vote && vote && (!fifo_full || pop);

    // Two-flop synchroniser plus previous-value register for edge detection; idle-high reset.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            sync1 <= 1'b1;
            rxs   <= 1'b1;
            rxs_d <= 1'b1;
        end else begin
            sync1 <= RX;
            rxs   <= sync1;
            rxs_d <= rxs;
        end
    end

    // First two of the three mid-bit samples; the third is rxs itself at the vote count.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            samp0 <= 1'b1;
            samp1 <= 1'b1;
        end else begin
            if (cnt == CNT_S0) samp0 <= rxs;
            if (cnt == CNT_S1) samp1 <= rxs;
        end
    end

    // Frame FSM with bit timer, shift register and registered error pulses.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state     <= S_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            FRAME_ERR <= 1'b0;
            OVERRUN   <= 1'b0;
        end else begin
            FRAME_ERR <= 1'b0;
            OVERRUN   <= 1'b0;
            cnt       <= at_last ? '0 : cnt + CW'(1);
            case (state)
                S_IDLE: begin
                    cnt <= '0;
                    if (rxs_d && !rxs) state <= S_START;
                end
                S_START: begin
                    if (at_vote && vote) begin
                        state <= S_IDLE;
                    end else if (at_last) begin
                        state   <= S_DATA;
                        bit_idx <= '0;
                    end
                end
                S_DATA: begin
                    if (at_vote) shreg <= {vote, shreg[7:1]};
                    if (at_last) begin
                        if (bit_idx == 3'd7) state <= S_STOP;
                        else                 bit_idx <= bit_idx + 3'd1;
                    end
                end
                S_STOP: begin
                    // Leave at the vote so a zero-gap next start bit is not missed.
                    if (at_vote) begin
                        if (vote) begin
                            if (fifo_full && !pop) OVERRUN <= 1'b1;
                            state <= S_IDLE;
                        end else begin
                            FRAME_ERR <= 1'b1;
                            state     <= S_WAIT_IDLE;
                        end
                    end
                end
                S_WAIT_IDLE: begin
                    if (rxs) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (CLK),
        .rst       (RESET),
        .push      (push),
        .push_data (shreg),
        .full      (fifo_full),
        .pop       (pop),
        .empty     (fifo_empty),
        .head      (DATA)
    );

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at DIV=16, DEPTH=4.
module tb_uart_rx;
    localparam int DIV = 16;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         exp_cnt;
        logic [7:0] exp_byte;
        int         exp_fe;
    } vec_t;

    logic       CLK   = 1'b0;
    logic       RESET = 1'b1;
    logic       RX    = 1'b1;
    logic       READY = 1'b0;
    logic [7:0] DATA;
    logic       VALID;
    logic       FRAME_ERR;
    logic       OVERRUN;

    int         tests = 0;
    int         fails = 0;
    int         fe_cnt = 0;
    int         ov_cnt = 0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];

    uart_rx #(
        .CLK_FREQ (48000000),
        .BAUD     (3000000),
        .DEPTH    (4)
    ) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .RX        (RX),
        .DATA      (DATA),
        .VALID     (VALID),
        .READY     (READY),
        .FRAME_ERR (FRAME_ERR),
        .OVERRUN   (OVERRUN)
    );

    // Clock
    always #5 CLK = ~CLK;

    // Monitor: transfers and pulses sampled mid-cycle
    always @(negedge CLK) begin
        if (VALID && READY) got_q.push_back(DATA);
        if (FRAME_ERR) fe_cnt++;
        if (OVERRUN) ov_cnt++;
    end

    // Time limit
    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, got %0d tests, required finish", tests);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_bits(input int bits);
        RX = 1'b1;
        repeat (bits * DIV) tick();
    endtask

    // Drives one 8N1 frame, LSB first; RX is left at the stop level.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        RX = 1'b0;
        repeat (DIV) tick();
        for (int i = 0; i < 8; i++) begin
            RX = b[i];
            repeat (DIV) tick();
        end
        RX = stop_bit;
        repeat (DIV) tick();
    endtask

    initial begin
        vec_t vecs[8];
        int   lat;
        int   n0;
        int   fe0;
        int   ov0;
        int   base;
        logic rnd_done;
        logic [7:0] b;
        logic stop_ok;

        vecs[0] = '{8'h00, 1'b1, 1, 8'h00, 0};
        vecs[1] = '{8'hFF, 1'b1, 1, 8'hFF, 0};
        vecs[2] = '{8'h80, 1'b1, 1, 8'h80, 0};
        vecs[3] = '{8'h01, 1'b1, 1, 8'h01, 0};
        vecs[4] = '{8'hC3, 1'b0, 0, 8'h00, 1};
        vecs[5] = '{8'h7E, 1'b1, 1, 8'h7E, 0};
        vecs[6] = '{8'hAA, 1'b0, 0, 8'h00, 1};
        vecs[7] = '{8'h33, 1'b1, 1, 8'h33, 0};

        // Reset state
        repeat (3) tick();
        chk("rst_valid_in_reset", 32'(VALID), 32'd0);
        RESET = 1'b0;
        tick();
        chk("rst_data", 32'(DATA), 32'h00);
        chk("rst_valid", 32'(VALID), 32'd0);
        chk("rst_frame_err", 32'(FRAME_ERR), 32'd0);
        chk("rst_overrun", 32'(OVERRUN), 32'd0);
        idle_bits(2);

        // 1: 0xA5, latency = 3 cycles to START entry + 154
        READY = 1'b1;
        n0 = got_q.size();
        fork
            send_frame(8'hA5, 1'b1);
            begin
                lat = 0;
                while (!VALID && lat < 400) begin
                    tick();
                    lat++;
                end
                chk("t1_latency", 32'(lat), 32'd157);
                chk("t1_data", 32'(DATA), 32'hA5);
                tick();
                chk("t1_valid_one_cycle", 32'(VALID), 32'd0);
            end
        join
        idle_bits(2);
        chk("t1_count", 32'(got_q.size() - n0), 32'd1);
        chk("t1_frame_err", 32'(fe_cnt), 32'd0);
        chk("t1_overrun", 32'(ov_cnt), 32'd0);

        // 2: 4-cycle glitch is a false start
        n0 = got_q.size();
        fe0 = fe_cnt;
        RX = 1'b0;
        repeat (4) tick();
        RX = 1'b1;
        repeat (3 * DIV) tick();
        chk("t2_fsm_idle", 32'(dut.state), 32'(uart_pkg::S_IDLE));
        chk("t2_no_byte", 32'(got_q.size() - n0), 32'd0);
        chk("t2_no_fe", 32'(fe_cnt - fe0), 32'd0);
        send_frame(8'h5A, 1'b1);
        idle_bits(2);
        chk("t2_count", 32'(got_q.size() - n0), 32'd1);
        chk("t2_data", 32'(got_q[got_q.size() - 1]), 32'h5A);

        // 3: bad stop, long break, then 0x3C
        n0 = got_q.size();
        fe0 = fe_cnt;
        send_frame(8'h55, 1'b0);
        repeat (40 * DIV) tick();
        idle_bits(2);
        send_frame(8'h3C, 1'b1);
        idle_bits(2);
        chk("t3_one_fe", 32'(fe_cnt - fe0), 32'd1);
        chk("t3_count", 32'(got_q.size() - n0), 32'd1);
        chk("t3_data", 32'(got_q[got_q.size() - 1]), 32'h3C);

        // 4: fill with READY low, fifth byte overruns, then drain
        READY = 1'b0;
        ov0 = ov_cnt;
        send_frame(8'h01, 1'b1);
        chk("t4_valid_after_first", 32'(VALID), 32'd1);
        for (int i = 2; i <= 5; i++) send_frame(8'(i), 1'b1);
        idle_bits(1);
        chk("t4_overrun", 32'(ov_cnt - ov0), 32'd1);
        READY = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk("t4_drain_valid", 32'(VALID), 32'd1);
            chk("t4_drain_data", 32'(DATA), 32'(i));
            tick();
        end
        chk("t4_empty", 32'(VALID), 32'd0);

        // 5a: zero-gap frames
        n0 = got_q.size();
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        idle_bits(1);
        chk("t5_count", 32'(got_q.size() - n0), 32'd2);
        chk("t5_first", 32'(got_q[n0]), 32'h00);
        chk("t5_second", 32'(got_q[n0 + 1]), 32'hFF);

        // 5b: full FIFO, pop coincides with the fifth stop vote
        READY = 1'b0;
        ov0 = ov_cnt;
        n0 = got_q.size();
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        send_frame(8'h33, 1'b1);
        send_frame(8'h44, 1'b1);
        fork
            send_frame(8'h55, 1'b1);
            begin
                repeat (156) tick();
                READY = 1'b1;
                tick();
                READY = 1'b0;
            end
        join
        idle_bits(1);
        chk("t5_no_overrun", 32'(ov_cnt - ov0), 32'd0);
        chk("t5_popped_11", 32'(got_q.size() - n0), 32'd1);
        if (got_q.size() > n0) chk("t5_popped_data", 32'(got_q[n0]), 32'h11);
        READY = 1'b1;
        for (int i = 2; i <= 5; i++) begin
            chk("t5_drain_data", 32'(DATA), 32'(8'h11 * i));
            tick();
        end
        chk("t5_empty", 32'(VALID), 32'd0);

        // 6: reset during data bit 4 with a queued byte
        READY = 1'b0;
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        send_frame(8'h77, 1'b1);
        idle_bits(1);
        chk("t6_queued", 32'(VALID), 32'd1);
        RX = 1'b0;
        repeat (5 * DIV) tick();
        RX = 1'b1;
        repeat (DIV / 2) tick();
        RESET = 1'b1;
        repeat (2) tick();
        RESET = 1'b0;
        chk("t6_valid_cleared", 32'(VALID), 32'd0);
        chk("t6_data_cleared", 32'(DATA), 32'h00);
        repeat (DIV / 2 - 2 + 4 * DIV) tick();
        idle_bits(1);
        chk("t6_valid", 32'(VALID), 32'd0);
        chk("t6_no_fe", 32'(fe_cnt - fe0), 32'd0);
        chk("t6_no_ov", 32'(ov_cnt - ov0), 32'd0);
        READY = 1'b1;
        n0 = got_q.size();
        send_frame(8'h81, 1'b1);
        idle_bits(1);
        chk("t6_count", 32'(got_q.size() - n0), 32'd1);
        chk("t6_data", 32'(got_q[got_q.size() - 1]), 32'h81);

        // Table-driven frames
        for (int i = 0; i < 8; i++) begin
            n0 = got_q.size();
            fe0 = fe_cnt;
            send_frame(vecs[i].data, vecs[i].stop);
            idle_bits(2);
            chk("vec_count", 32'(got_q.size() - n0), 32'(vecs[i].exp_cnt));
            chk("vec_fe", 32'(fe_cnt - fe0), 32'(vecs[i].exp_fe));
            if (vecs[i].exp_cnt == 1 && got_q.size() > n0)
                chk("vec_data", 32'(got_q[n0]), 32'(vecs[i].exp_byte));
        end

        // Random frames with random READY; model: good stop -> one byte, bad stop -> one error
        exp_q.delete();
        base = got_q.size();
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        lat = 0;
        rnd_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 30; i++) begin
                    b = 8'($urandom_range(0, 255));
                    stop_ok = ($urandom_range(0, 9) != 0);
                    if (stop_ok) exp_q.push_back(b);
                    else lat++;
                    send_frame(b, stop_ok);
                    idle_bits($urandom_range(1, 3));
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    tick();
                    READY = 1'($urandom_range(0, 1));
                end
            end
        join
        READY = 1'b1;
        idle_bits(2);
        chk("rnd_count", 32'(got_q.size() - base), 32'(exp_q.size()));
        chk("rnd_fe", 32'(fe_cnt - fe0), 32'(lat));
        chk("rnd_ov", 32'(ov_cnt - ov0), 32'd0);
        for (int i = base; i < got_q.size() && exp_q.size() > 0; i++)
            chk("rnd_data", 32'(got_q[i]), 32'(exp_q.pop_front()));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
